// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pattern index width and scene-sequencer state type.
// Also holds the wrap-around pattern stepping helper.
package vga_pkg;

  localparam int H_TOTAL   = 800;
  localparam int V_ACTIVE  = 480;
  localparam int V_TOTAL   = 525;
  localparam int PATTERN_W = 3;

  localparam logic [9:0] COMMIT_ROW = 10'(V_ACTIVE);
  localparam logic [9:0] LAST_ROW   = 10'(V_TOTAL - 1);
  localparam logic [9:0] LAST_COL   = 10'(H_TOTAL - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE   = 2'd0,
    ST_UPDATE   = 2'd1,
    ST_WAIT_TOP = 2'd2
  } state_t;

  // Step a pattern index up or down, wrapping within 0..count-1.
  function automatic logic [PATTERN_W-1:0] step_pattern(
    input logic [PATTERN_W-1:0] cur,
    input logic                 up,
    input int unsigned          count
  );
    logic [PATTERN_W-1:0] last;
    last = PATTERN_W'(count - 1);
    if (up) begin
      step_pattern = (cur == last) ? {PATTERN_W{1'b0}} : cur + 1'b1;
    end else begin
      step_pattern = (cur == {PATTERN_W{1'b0}}) ? last : cur - 1'b1;
    end
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for one raw button.
// Emits a one-cycle press pulse when the accepted level rises.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Any cycle where the synchronised input matches the accepted level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= {CW{1'b0}};
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= {CW{1'b0}};
      end else if (cnt == CNT_LAST) begin
        cnt   <= {CW{1'b0}};
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/scene_sequencer.sv
// Frame-synchronous pattern selector: commits button/auto changes at vblank start
// and runs a per-frame update handshake with overrun detection.
module scene_sequencer
  import vga_pkg::*;
#(
  parameter int NUM_PATTERNS    = 6,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int AUTO_FRAMES     = 120
) (
  input  logic                 pixel_clk,
  input  logic                 rst,
  input  logic [9:0]           row,
  input  logic [9:0]           column,
  input  logic                 btn_next,
  input  logic                 btn_prev,
  input  logic                 auto_en,
  input  logic                 update_ack,
  output logic [PATTERN_W-1:0] pattern_sel,
  output logic [15:0]          frame_count,
  output logic                 vblank_start,
  output logic                 update_req,
  output logic                 overrun
);

  localparam int AW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_FRAMES - 1);

  state_t               state;
  logic                 press_next;
  logic                 press_prev;
  logic                 pend_next;
  logic                 pend_prev;
  logic [AW-1:0]        auto_cnt;
  logic                 commit;
  logic                 frame_end;
  logic                 auto_step;
  logic [PATTERN_W-1:0] next_sel;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(pixel_clk), .rst(rst), .btn(btn_next), .press(press_next)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk(pixel_clk), .rst(rst), .btn(btn_prev), .press(press_prev)
  );

  // Commit/frame-end decode and the pattern that would be chosen at this commit.
  always_comb begin
    commit    = (state == ST_ACTIVE) && (row == COMMIT_ROW) && (column == 10'd0);
    frame_end = (row == LAST_ROW) && (column == LAST_COL);
    auto_step = auto_en && !pend_next && !pend_prev && (auto_cnt == AUTO_LAST);
    if (pend_next && !pend_prev) begin
      next_sel = step_pattern(pattern_sel, 1'b1, NUM_PATTERNS);
    end else if (pend_prev && !pend_next) begin
      next_sel = step_pattern(pattern_sel, 1'b0, NUM_PATTERNS);
    end else if (auto_step) begin
      next_sel = step_pattern(pattern_sel, 1'b1, NUM_PATTERNS);
    end else begin
      next_sel = pattern_sel;
    end
  end

  // Sequencer FSM with registered outputs; presses seen in the commit cycle carry over.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state        <= ST_ACTIVE;
      pattern_sel  <= {PATTERN_W{1'b0}};
      frame_count  <= 16'd0;
      vblank_start <= 1'b0;
      update_req   <= 1'b0;
      overrun      <= 1'b0;
      pend_next    <= 1'b0;
      pend_prev    <= 1'b0;
      auto_cnt     <= {AW{1'b0}};
    end else begin
      vblank_start <= 1'b0;
      if (commit) begin
        pend_next <= press_next;
        pend_prev <= press_prev;
      end else begin
        pend_next <= pend_next | press_next;
        pend_prev <= pend_prev | press_prev;
      end

      // The auto counter wraps at AUTO_FRAMES so a cancelled step cannot skip past it.
      if (!auto_en) begin
        auto_cnt <= {AW{1'b0}};
      end else if (commit) begin
        if ((next_sel != pattern_sel) || (auto_cnt == AUTO_LAST)) begin
          auto_cnt <= {AW{1'b0}};
        end else begin
          auto_cnt <= auto_cnt + 1'b1;
        end
      end else begin
        auto_cnt <= auto_cnt;
      end

      case (state)
        ST_ACTIVE: begin
          if (commit) begin
            vblank_start <= 1'b1;
            frame_count  <= frame_count + 16'd1;
            pattern_sel  <= next_sel;
            update_req   <= 1'b1;
            state        <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          if (update_ack) begin
            update_req <= 1'b0;
            state      <= ST_WAIT_TOP;
          end else if (frame_end) begin
            update_req <= 1'b0;
            overrun    <= 1'b1;
            state      <= ST_ACTIVE;
          end
        end
        ST_WAIT_TOP: begin
          if ((row == 10'd0) && (column == 10'd0)) begin
            state <= ST_ACTIVE;
          end
        end
        default: begin
          update_req <= 1'b0;
          state      <= ST_ACTIVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scene_sequencer.sv
// Self-checking bench for scene_sequencer: row/column are driven as a compressed
// frame touching only the positions that matter, against a frame-level reference model.
module tb_scene_sequencer;

  localparam int NP  = 6;
  localparam int DEB = 4;
  localparam int AF  = 3;

  logic        pixel_clk = 1'b0;
  logic        rst;
  logic [9:0]  row;
  logic [9:0]  column;
  logic        btn_next;
  logic        btn_prev;
  logic        auto_en;
  logic        update_ack;
  logic [2:0]  pattern_sel;
  logic [15:0] frame_count;
  logic        vblank_start;
  logic        update_req;
  logic        overrun;

  int nvec  = 0;
  int nfail = 0;

  // Reference model state
  int exp_pat = 0;
  int exp_cnt = 0;
  int exp_fc  = 0;
  bit exp_ovr = 1'b0;
  bit mpend_n = 1'b0;
  bit mpend_p = 1'b0;

  always #5 pixel_clk = ~pixel_clk;

  scene_sequencer #(
    .NUM_PATTERNS(NP), .DEBOUNCE_CYCLES(DEB), .AUTO_FRAMES(AF)
  ) dut (
    .pixel_clk(pixel_clk), .rst(rst), .row(row), .column(column),
    .btn_next(btn_next), .btn_prev(btn_prev), .auto_en(auto_en),
    .update_ack(update_ack), .pattern_sel(pattern_sel),
    .frame_count(frame_count), .vblank_start(vblank_start),
    .update_req(update_req), .overrun(overrun)
  );

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic model_reset();
    exp_pat = 0; exp_cnt = 0; exp_fc = 0;
    exp_ovr = 1'b0; mpend_n = 1'b0; mpend_p = 1'b0;
  endtask

  // Frame-level rules: pending direction wins, both cancel, otherwise auto every AF commits.
  task automatic model_commit();
    int p;
    p = exp_pat;
    if (mpend_n && !mpend_p)                             p = (p + 1) % NP;
    else if (mpend_p && !mpend_n)                        p = (p + NP - 1) % NP;
    else if (!mpend_n && !mpend_p && auto_en && exp_cnt == AF - 1) p = (p + 1) % NP;
    if (!auto_en || p != exp_pat) exp_cnt = 0;
    else                          exp_cnt = (exp_cnt + 1) % AF;
    exp_pat = p;
    exp_fc  = (exp_fc + 1) % 65536;
    mpend_n = 1'b0;
    mpend_p = 1'b0;
  endtask

  task automatic frame_start();
    row = 10'd0; column = 10'd0;
    tick();
    row = 10'd1; column = 10'd3;
  endtask

  task automatic press_buttons(input int nlen, input int plen);
    row = 10'd100; column = 10'd5;
    if (nlen > 0) begin
      btn_next = 1'b1; repeat (nlen) tick();
      btn_next = 1'b0; repeat (12) tick();
    end
    if (plen > 0) begin
      btn_prev = 1'b1; repeat (plen) tick();
      btn_prev = 1'b0; repeat (12) tick();
    end
    if (nlen >= DEB) mpend_n = 1'b1;
    if (plen >= DEB) mpend_p = 1'b1;
  endtask

  task automatic do_commit(input string tag);
    row = 10'd100; column = 10'd7;
    tick();
    nvec++;
    if (pattern_sel !== 3'(exp_pat)) begin
      nfail++; $display("FAIL %s pre-commit pattern_sel: got %0d want %0d", tag, pattern_sel, exp_pat);
    end
    row = 10'd480; column = 10'd0;
    tick();
    model_commit();
    nvec++;
    if (vblank_start !== 1'b1 || update_req !== 1'b1) begin
      nfail++; $display("FAIL %s commit vblank/req: got %b%b want 11", tag, vblank_start, update_req);
    end
    nvec++;
    if (pattern_sel !== 3'(exp_pat) || frame_count !== 16'(exp_fc) || overrun !== exp_ovr) begin
      nfail++; $display("FAIL %s commit sel/fc/ovr: got %0d/%0d/%b want %0d/%0d/%b",
                        tag, pattern_sel, frame_count, overrun, exp_pat, exp_fc, exp_ovr);
    end
    column = 10'd1;
    tick();
    nvec++;
    if (vblank_start !== 1'b0) begin
      nfail++; $display("FAIL %s vblank pulse width: got %b want 0", tag, vblank_start);
    end
  endtask

  // mode 0: ack after delay; 1: never ack; 2: ack coincident with frame end
  task automatic finish_frame(input string tag, input int ack_delay, input int mode);
    row = 10'd481; column = 10'd3;
    repeat (ack_delay) tick();
    nvec++;
    if (update_req !== 1'b1) begin
      nfail++; $display("FAIL %s req held: got %b want 1", tag, update_req);
    end
    if (mode == 0) begin
      update_ack = 1'b1; tick(); update_ack = 1'b0;
      nvec++;
      if (update_req !== 1'b0) begin
        nfail++; $display("FAIL %s req drop after ack: got %b want 0", tag, update_req);
      end
      row = 10'd524; column = 10'd799; tick();
    end else if (mode == 1) begin
      row = 10'd524; column = 10'd799; tick();
      exp_ovr = 1'b1;
    end else begin
      row = 10'd524; column = 10'd799; update_ack = 1'b1; tick(); update_ack = 1'b0;
    end
    nvec++;
    if (update_req !== 1'b0 || overrun !== exp_ovr) begin
      nfail++; $display("FAIL %s frame end req/ovr: got %b/%b want 0/%b", tag, update_req, overrun, exp_ovr);
    end
    frame_start();
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_next = 1'b0; btn_prev = 1'b0; auto_en = 1'b0; update_ack = 1'b0;
    row = 10'd0; column = 10'd0;
    tick(); tick();
    nvec++;
    if ({pattern_sel, frame_count, vblank_start, update_req, overrun} !== 22'd0) begin
      nfail++; $display("FAIL reset outputs: got sel=%0d fc=%0d vb=%b req=%b ovr=%b want all 0",
                        pattern_sel, frame_count, vblank_start, update_req, overrun);
    end
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_idle_frames();
    auto_en = 1'b0;
    for (int f = 0; f < 2; f++) begin
      row = 10'd100; column = 10'd5; update_ack = 1'b1; tick(); update_ack = 1'b0;
      nvec++;
      if (update_req !== 1'b0) begin
        nfail++; $display("FAIL stray ack in active: got req=%b want 0", update_req);
      end
      do_commit("idle");
      finish_frame("idle", 10, 0);
    end
  endtask

  task automatic test_next_press();
    press_buttons(10, 0);
    do_commit("next");
    finish_frame("next", 4, 0);
    press_buttons(3, 0);
    do_commit("glitch");
    finish_frame("glitch", 4, 0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6; i++) begin
      press_buttons(10, 0); do_commit("wrap_next"); finish_frame("wrap_next", 3, 0);
    end
    for (int i = 0; i < 2; i++) begin
      press_buttons(0, 10); do_commit("wrap_prev"); finish_frame("wrap_prev", 3, 0);
    end
  endtask

  task automatic test_cancel();
    press_buttons(10, 10); do_commit("cancel"); finish_frame("cancel", 2, 0);
    press_buttons(0, 0);   do_commit("cancel_after"); finish_frame("cancel_after", 2, 0);
  endtask

  task automatic test_auto();
    auto_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      if (f == 4) press_buttons(10, 0);
      do_commit("auto"); finish_frame("auto", 2, 0);
    end
    auto_en = 1'b0;
  endtask

  // Press pulse lands exactly in the commit cycle and must carry to the next frame.
  task automatic test_press_at_commit();
    row = 10'd100; column = 10'd9;
    btn_next = 1'b1;
    repeat (5) tick();
    do_commit("at_commit");
    mpend_n = 1'b1;
    tick(); tick();
    btn_next = 1'b0;
    repeat (12) tick();
    finish_frame("at_commit", 2, 0);
    do_commit("at_commit_next"); finish_frame("at_commit_next", 2, 0);
  endtask

  task automatic test_ack_at_end();
    do_commit("ack_end"); finish_frame("ack_end", 5, 2);
  endtask

  task automatic test_overrun();
    do_commit("overrun"); finish_frame("overrun", 6, 1);
    for (int f = 0; f < 2; f++) begin
      do_commit("overrun_sticky"); finish_frame("overrun_sticky", 3, 0);
    end
  endtask

  task automatic test_random();
    int lens[4] = '{0, 3, 4, 10};
    for (int f = 0; f < 30; f++) begin
      auto_en = 1'($urandom_range(1, 0));
      press_buttons(lens[$urandom_range(3, 0)], lens[$urandom_range(3, 0)]);
      do_commit("random");
      finish_frame("random", int'($urandom_range(20, 1)), ($urandom_range(9, 0) == 0) ? 2 : 0);
    end
    auto_en = 1'b0;
  endtask

  task automatic test_reset_mid_update();
    press_buttons(10, 0);
    do_commit("mid_rst_pre");
    rst = 1'b1;
    #2;
    nvec++;
    if ({pattern_sel, frame_count, vblank_start, update_req, overrun} !== 22'd0) begin
      nfail++; $display("FAIL async reset: got sel=%0d fc=%0d vb=%b req=%b ovr=%b want all 0",
                        pattern_sel, frame_count, vblank_start, update_req, overrun);
    end
    tick(); tick();
    rst = 1'b0;
    model_reset();
    row = 10'd200; column = 10'd0;
    tick();
    do_commit("post_rst"); finish_frame("post_rst", 3, 0);
  endtask

  initial begin
    test_reset();
    test_idle_frames();
    test_next_press();
    test_wrap();
    test_cancel();
    test_auto();
    test_press_at_commit();
    test_ack_at_end();
    test_overrun();
    test_random();
    test_reset_mid_update();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
